// File: rtl/note_pkg.sv
// Shared constants and state encoding for the note recorder.
package note_pkg;

  localparam int unsigned NOTE_W       = 6;
  localparam logic [NOTE_W-1:0] REST   = '0;
  localparam int unsigned EIGHTH_TICKS = 34816000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REC  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/slot_ram.sv
// Simple dual-port slot memory: one write port, one registered read-first read port.
module slot_ram #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 160
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     we_in,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_in,
  input  logic [WIDTH-1:0]         wr_data_in,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_in,
  input  logic                     rd_zero_in,
  output logic [WIDTH-1:0]         rd_data_out
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_q;

  always_ff @(posedge clk_in) begin
    if (we_in) begin
      mem_q[wr_addr_in] <= wr_data_in;
    end
  end

  // Output register carries a synchronous clear so it still maps onto a BRAM output stage.
  always_ff @(posedge clk_in) begin
    if (rst_in || rd_zero_in) begin
      rd_q <= '0;
    end else begin
      rd_q <= mem_q[rd_addr_in];
    end
  end

  assign rd_data_out = rd_q;

endmodule

// File: rtl/note_recorder.sv
// Multi-voice note recorder: while toggle_in is high, slices time into P-cycle slots
// and stores the last valid note of each voice per slot into slot_ram.
module note_recorder #(
  parameter int unsigned NOTE_W = note_pkg::NOTE_W,
  parameter int unsigned VOICES = 2,
  parameter int unsigned DEPTH  = 160,
  parameter int unsigned TICK_W = 26
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       toggle_in,
  input  logic                       loop_in,
  input  logic [TICK_W-1:0]          ticks_per_slot_in,
  input  logic [VOICES*NOTE_W-1:0]   note_in,
  input  logic [VOICES-1:0]          note_valid_in,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr_in,
  output logic [VOICES*NOTE_W-1:0]   rd_data_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out,
  output logic                       recording_out,
  output logic                       full_out,
  output logic                       wrapped_out,
  output logic                       slot_strobe_out
);
  import note_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned DW = VOICES * NOTE_W;
  localparam logic [DW-1:0] REST_WORD = {VOICES{NOTE_W'(REST)}};

  state_e            state_q;
  logic              toggle_q;
  logic              loop_q;
  logic              rec_q;
  logic              full_q;
  logic              wrapped_q;
  logic              strobe_q;
  logic [TICK_W-1:0] period_q;
  logic [TICK_W-1:0] tick_q;
  logic [AW-1:0]     wr_ptr_q;
  logic [CW-1:0]     count_q;
  logic [DW-1:0]     cap_q;

  logic [DW-1:0]     cap_d;
  logic [TICK_W-1:0] period_d;
  logic              rise_c;
  logic              slot_end_c;
  logic              last_slot_c;
  logic              we_c;
  logic              rd_zero_c;

  // Capture including this cycle's samples, so a note valid on the commit cycle is kept.
  always_comb begin
    cap_d = cap_q;
    for (int unsigned v = 0; v < VOICES; v++) begin
      if (note_valid_in[v]) begin
        cap_d[v*NOTE_W +: NOTE_W] = note_in[v*NOTE_W +: NOTE_W];
      end
    end
  end

  assign rise_c      = toggle_in & ~toggle_q;
  assign period_d    = (ticks_per_slot_in == '0) ? TICK_W'(1) : ticks_per_slot_in;
  assign slot_end_c  = (tick_q == period_q - TICK_W'(1));
  assign last_slot_c = (wr_ptr_q == AW'(DEPTH - 1));
  assign we_c        = (state_q == REC) && toggle_in && slot_end_c;
  // wrapped_q only ever sets together with a saturated count, so the count test covers it.
  assign rd_zero_c   = !(CW'(rd_addr_in) < count_q);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      toggle_q  <= 1'b0;
      loop_q    <= 1'b0;
      rec_q     <= 1'b0;
      full_q    <= 1'b0;
      wrapped_q <= 1'b0;
      strobe_q  <= 1'b0;
      period_q  <= TICK_W'(1);
      tick_q    <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      cap_q     <= REST_WORD;
    end else begin
      toggle_q <= toggle_in;
      strobe_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rise_c) begin
            state_q   <= REC;
            rec_q     <= 1'b1;
            loop_q    <= loop_in;
            period_q  <= period_d;
            tick_q    <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            wrapped_q <= 1'b0;
            cap_q     <= REST_WORD;
          end
        end
        REC: begin
          if (!toggle_in) begin
            state_q <= IDLE;
            rec_q   <= 1'b0;
          end else if (slot_end_c) begin
            strobe_q <= 1'b1;
            tick_q   <= '0;
            cap_q    <= REST_WORD;
            if (count_q != CW'(DEPTH)) begin
              count_q <= count_q + CW'(1);
            end
            if (last_slot_c) begin
              full_q   <= 1'b1;
              wr_ptr_q <= '0;
              if (loop_q) begin
                wrapped_q <= 1'b1;
              end else begin
                state_q <= DONE;
                rec_q   <= 1'b0;
              end
            end else begin
              wr_ptr_q <= wr_ptr_q + AW'(1);
            end
          end else begin
            tick_q <= tick_q + TICK_W'(1);
            cap_q  <= cap_d;
          end
        end
        DONE: begin
          if (!toggle_in) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          rec_q   <= 1'b0;
        end
      endcase
    end
  end

  slot_ram #(
    .WIDTH (DW),
    .DEPTH (DEPTH)
  ) u_slot_ram (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .we_in       (we_c),
    .wr_addr_in  (wr_ptr_q),
    .wr_data_in  (cap_d),
    .rd_addr_in  (rd_addr_in),
    .rd_zero_in  (rd_zero_c),
    .rd_data_out (rd_data_out)
  );

  assign count_out       = count_q;
  assign recording_out   = rec_q;
  assign full_out        = full_q;
  assign wrapped_out     = wrapped_q;
  assign slot_strobe_out = strobe_q;

endmodule

// File: tb/tb_note_recorder.sv
// Bench for note_recorder: directed scenarios plus a randomized run against a slot-level model.
module tb_note_recorder;

  localparam int V  = 2;
  localparam int NW = 6;
  localparam int D  = 4;
  localparam int TW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            toggle = 1'b0;
  logic            loop = 1'b0;
  logic [TW-1:0]   ticks = 8'd4;
  logic [V*NW-1:0] note = '0;
  logic [V-1:0]    valid = '0;
  logic [1:0]      rd_addr = '0;
  logic [V*NW-1:0] rd_data;
  logic [2:0]      count;
  logic            rec, full, wrapped, strobe;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  note_recorder #(.NOTE_W(NW), .VOICES(V), .DEPTH(D), .TICK_W(TW)) dut (
    .clk_in            (clk),
    .rst_in            (rst),
    .toggle_in         (toggle),
    .loop_in           (loop),
    .ticks_per_slot_in (ticks),
    .note_in           (note),
    .note_valid_in     (valid),
    .rd_addr_in        (rd_addr),
    .rd_data_out       (rd_data),
    .count_out         (count),
    .recording_out     (rec),
    .full_out          (full),
    .wrapped_out       (wrapped),
    .slot_strobe_out   (strobe)
  );

  // Reference model: a take is a sequence of P-sample slots; each voice keeps its last valid note.
  int              m_state;   // 0 idle, 1 recording, 2 finished one-shot
  bit              m_prev, m_loop, m_full, m_wrapped, m_strobe, m_rise;
  int              m_p, m_nsamp, m_commits, m_count;
  int              m_last [V];
  logic [V*NW-1:0] m_mem [D];
  logic [V*NW-1:0] m_rd = '0;
  logic [V*NW-1:0] m_word;

  always @(posedge clk) begin
    m_rd = ((int'(rd_addr) < m_count) || m_wrapped) ? m_mem[rd_addr] : '0;
    m_strobe = 1'b0;
    if (rst) begin
      m_state = 0; m_prev = 1'b0; m_count = 0; m_full = 1'b0; m_wrapped = 1'b0; m_rd = '0;
    end else begin
      m_rise = toggle && !m_prev;
      m_prev = toggle;
      if (m_state == 0) begin
        if (m_rise) begin
          m_state = 1; m_loop = loop; m_p = (ticks == 0) ? 1 : int'(ticks);
          m_nsamp = 0; m_commits = 0; m_count = 0; m_full = 1'b0; m_wrapped = 1'b0;
          for (int v = 0; v < V; v++) m_last[v] = 0;
        end
      end else if (!toggle) begin
        m_state = 0;
      end else if (m_state == 1) begin
        m_nsamp++;
        for (int v = 0; v < V; v++) if (valid[v]) m_last[v] = int'(note[v*NW +: NW]);
        if (m_nsamp == m_p) begin
          for (int v = 0; v < V; v++) m_word[v*NW +: NW] = NW'(m_last[v]);
          m_mem[m_commits % D] = m_word;
          m_commits++;
          m_count = (m_commits > D) ? D : m_commits;
          m_strobe = 1'b1;
          m_nsamp = 0;
          for (int v = 0; v < V; v++) m_last[v] = 0;
          if (m_commits % D == 0) begin
            m_full = 1'b1;
            if (m_loop) m_wrapped = 1'b1;
            else m_state = 2;
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic end_take();
    toggle = 1'b0; valid = '0;
    step(1);
  endtask

  task automatic test_reset();
    rst = 1'b1; toggle = 1'b0; note = 12'($urandom); valid = 2'b11;
    step(2);
    total++;
    if ({count, rec, full, wrapped, strobe, rd_data} !== '0)
      begin bad++; $display("FAIL reset_outputs got=%h exp=0", {count, rec, full, wrapped, strobe, rd_data}); end
    rst = 1'b0; valid = '0;
    step(1);
    total++;
    if (rec !== 1'b0) begin bad++; $display("FAIL reset_idle rec=%b exp=0", rec); end
  endtask

  task automatic test_basic();
    ticks = 8'd4; loop = 1'b0; valid = 2'b01;
    toggle = 1'b1;
    step(1);
    total++;
    if (rec !== 1'b1) begin bad++; $display("FAIL basic_rec_start rec=%b exp=1", rec); end
    for (int k = 1; k <= 16; k++) begin
      note = {NW'($urandom), 6'd12};
      step(1);
      total++;
      if (strobe !== (k % 4 == 0)) begin bad++; $display("FAIL basic_strobe k=%0d got=%b", k, strobe); end
      total++;
      if (count !== 3'(k / 4)) begin bad++; $display("FAIL basic_count k=%0d got=%0d exp=%0d", k, count, k / 4); end
    end
    total++;
    if ({rec, full} !== 2'b01) begin bad++; $display("FAIL basic_done rec=%b full=%b exp rec=0 full=1", rec, full); end
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      step(1);
      total++;
      if (rd_data !== 12'd12) begin bad++; $display("FAIL basic_read addr=%0d got=%h exp=00c", i, rd_data); end
    end
    end_take();
  endtask

  task automatic test_last_wins();
    ticks = 8'd4; loop = 1'b0; valid = '0;
    toggle = 1'b1;
    step(1);
    for (int k = 1; k <= 8; k++) begin
      valid = {1'b0, (k == 1 || k == 3 || k == 8)};
      note  = {NW'($urandom), (k == 1) ? 6'd5 : (k == 3) ? 6'd9 : (k == 8) ? 6'd33 : NW'($urandom)};
      step(1);
    end
    valid = '0;
    rd_addr = 2'd0; step(1);
    total++;
    if (rd_data !== 12'd9) begin bad++; $display("FAIL last_wins got=%h exp=009", rd_data); end
    rd_addr = 2'd1; step(1);
    total++;
    if (rd_data !== 12'd33) begin bad++; $display("FAIL commit_cycle_note got=%h exp=021", rd_data); end
    end_take();
  endtask

  task automatic test_loop();
    logic [5:0] exp_slot [4];
    exp_slot[0] = 6'd5; exp_slot[1] = 6'd6; exp_slot[2] = 6'd3; exp_slot[3] = 6'd4;
    ticks = 8'd4; loop = 1'b1; valid = 2'b01;
    toggle = 1'b1;
    step(1);
    for (int s = 0; s < 6; s++) begin
      note = {6'd0, 6'(s + 1)};
      step(4);
    end
    total++;
    if ({rec, full, wrapped, count} !== 6'b111100)
      begin bad++; $display("FAIL loop_flags rec=%b full=%b wrapped=%b count=%0d exp 1 1 1 4", rec, full, wrapped, count); end
    valid = '0;
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      step(1);
      total++;
      if (rd_data !== {6'd0, exp_slot[i]})
        begin bad++; $display("FAIL loop_read addr=%0d got=%h exp=%h", i, rd_data, {6'd0, exp_slot[i]}); end
    end
    loop = 1'b0;
    end_take();
  endtask

  task automatic test_abort();
    ticks = 8'd4; loop = 1'b0; valid = 2'b11;
    toggle = 1'b1;
    step(1);
    total++;
    if ({wrapped, full, count} !== 5'd0)
      begin bad++; $display("FAIL abort_start_clear wrapped=%b full=%b count=%0d exp 0", wrapped, full, count); end
    for (int k = 1; k <= 10; k++) begin
      note = 12'($urandom);
      step(1);
    end
    toggle = 1'b0;
    step(1);
    total++;
    if ({count, rec, strobe} !== 5'b01000)
      begin bad++; $display("FAIL abort_count count=%0d rec=%b strobe=%b exp 2 0 0", count, rec, strobe); end
    rd_addr = 2'd2; step(1);
    total++;
    if (rd_data !== '0) begin bad++; $display("FAIL abort_partial_read got=%h exp=000", rd_data); end
    rd_addr = 2'd1; step(1);
    total++;
    if (rd_data !== m_rd) begin bad++; $display("FAIL abort_kept_read got=%h exp=%h", rd_data, m_rd); end
    toggle = 1'b1;
    rd_addr = 2'd0;
    step(1);
    total++;
    if (count !== 3'd0) begin bad++; $display("FAIL retake_count got=%0d exp=0", count); end
    step(1);
    total++;
    if (rd_data !== '0) begin bad++; $display("FAIL retake_old_read got=%h exp=000", rd_data); end
    end_take();
  endtask

  task automatic test_toggle_vs_commit();
    ticks = 8'd4; loop = 1'b0; valid = 2'b11; note = 12'($urandom);
    toggle = 1'b1;
    step(8);
    toggle = 1'b0;
    step(1);
    total++;
    if ({count, strobe, rec} !== 5'b00100)
      begin bad++; $display("FAIL toggle_beats_commit count=%0d strobe=%b rec=%b exp 1 0 0", count, strobe, rec); end
    end_take();
  endtask

  task automatic test_period_zero();
    ticks = 8'd0; loop = 1'b0; valid = 2'b10;
    toggle = 1'b1;
    step(1);
    for (int k = 1; k <= 4; k++) begin
      note = 12'($urandom);
      step(1);
      total++;
      if ({strobe, count} !== {1'b1, 3'(k)})
        begin bad++; $display("FAIL p0_commit k=%0d strobe=%b count=%0d exp 1 %0d", k, strobe, count, k); end
    end
    total++;
    if ({rec, full} !== 2'b01) begin bad++; $display("FAIL p0_done rec=%b full=%b exp 0 1", rec, full); end
    end_take();
  endtask

  task automatic test_period_change();
    ticks = 8'd4; loop = 1'b0; valid = '0;
    toggle = 1'b1;
    step(1);
    ticks = 8'd8;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      total++;
      if (strobe !== (k == 4 || k == 8)) begin bad++; $display("FAIL period_latch k=%0d strobe=%b", k, strobe); end
    end
    end_take();
  endtask

  task automatic test_reset_mid();
    ticks = 8'd4; loop = 1'b1; valid = 2'b11; note = 12'($urandom);
    toggle = 1'b1;
    step(7);
    rst = 1'b1;
    step(1);
    total++;
    if ({count, rec, full, wrapped, strobe, rd_data} !== '0)
      begin bad++; $display("FAIL reset_mid got=%h exp=0", {count, rec, full, wrapped, strobe, rd_data}); end
    rst = 1'b0;
    step(1);
    total++;
    if (rec !== 1'b1) begin bad++; $display("FAIL toggle_through_reset rec=%b exp=1", rec); end
    loop = 1'b0;
    end_take();
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      step(1);
      total++;
      if (rd_data !== '0) begin bad++; $display("FAIL reset_read addr=%0d got=%h exp=000", i, rd_data); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 19) == 0) toggle = ~toggle;
      rst     = ($urandom_range(0, 199) == 0);
      loop    = 1'($urandom);
      ticks   = 8'($urandom_range(0, 3));
      note    = 12'($urandom);
      valid   = 2'($urandom);
      rd_addr = 2'($urandom);
      step(1);
      total++;
      if (rd_data !== m_rd) begin bad++; $display("FAIL rnd_rd c=%0d got=%h exp=%h", c, rd_data, m_rd); end
      total++;
      if (count !== 3'(m_count)) begin bad++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, count, m_count); end
      total++;
      if (rec !== (m_state == 1)) begin bad++; $display("FAIL rnd_rec c=%0d got=%b exp=%b", c, rec, m_state == 1); end
      total++;
      if ({full, wrapped, strobe} !== {m_full, m_wrapped, m_strobe})
        begin bad++; $display("FAIL rnd_flags c=%0d got=%b exp=%b", c, {full, wrapped, strobe}, {m_full, m_wrapped, m_strobe}); end
    end
    rst = 1'b0;
    end_take();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_last_wins();
    test_loop();
    test_abort();
    test_toggle_vs_commit();
    test_period_zero();
    test_period_change();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
